// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Grants one requester at a time for up to BURST_LEN words, honouring w_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int BW        = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          w_full,
  output logic                          w_push,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [BW-1:0]  beat_cnt;
  logic [IDW-1:0] pick;
  logic           in_grant;
  logic           owner_req;
  logic           xfer;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    logic found;
    int   cand;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end
  end

  // Outputs gated by rst so nothing is pushed in a reset cycle.
  assign in_grant  = (state == GRANT) && !rst;
  assign owner_req = req[grant_id];
  assign xfer      = in_grant && owner_req && !w_full;
  assign w_push    = xfer;
  assign req_ack   = xfer ? (NUM_REQ'(1) << grant_id) : '0;
  assign w_data    = in_grant ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      word_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
            beat_cnt <= beat_cnt + BW'(1);
            if (beat_cnt == BW'(BURST_LEN - 1)) begin
              last_grant <= grant_id;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (!owner_req) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ack;
  logic             w_full = 1'b0;
  logic             w_push;
  logic [DW-1:0]    w_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic [CW-1:0]    word_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .w_full(w_full), .w_push(w_push), .w_data(w_data), .grant_id(grant_id),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rem[NR];
  logic [DW-1:0] dat[NR];

  logic          s_push, s_busy;
  logic [NR-1:0] s_ack;
  logic [DW-1:0] s_wdata;
  logic [1:0]    s_gid;
  logic [CW-1:0] s_wcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req[i]            = (rem[i] != 0);
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic expect_burst(input int id, input int d0, input int n, input int c0);
    for (int j = 0; j < n; j++) sb.push_back('{id, (d0 + j) & 8'hff, c0 + j});
  endtask

  // Sample on the falling edge, pop the scoreboard on each push, then let the
  // modelled requesters react to the acks just after the rising edge.
  task automatic cycle();
    logic [NR-1:0] acked;
    exp_t e;
    @(negedge clk);
    cyc++;
    s_push = w_push; s_ack = req_ack; s_wdata = w_data;
    s_busy = busy;   s_gid = grant_id; s_wcnt = word_cnt;
    check("invariant", {31'd0, !(w_push && w_full) && (w_push == |req_ack) && $onehot0(req_ack)}, 1);
    if (w_push) begin
      if (sb.size() == 0) begin
        check("unexpected_push", {24'd0, w_data}, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check("push_cycle", cyc, e.cyc);
        check("w_data", {24'd0, w_data}, e.data);
        check("grant_id", {30'd0, grant_id}, e.id);
        check("req_ack", {28'd0, req_ack}, 32'd1 << e.id);
      end
    end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
      check("missing_push", 0, 1);
    end
    acked = req_ack & req;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acked[i]) begin
        rem[i]--;
        dat[i]++;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    apply();
    cycle();
    cycle();
    rst = 1'b0;
    sb.delete();
    cyc = 0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle();
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    // reset values
    do_reset();
    check("rst_busy", {31'd0, s_busy}, 0);
    check("rst_push", {31'd0, s_push}, 0);
    check("rst_ack", {28'd0, s_ack}, 0);
    check("rst_wdata", {24'd0, s_wdata}, 0);
    check("rst_gid", {30'd0, s_gid}, 0);
    check("rst_wcnt", {28'd0, s_wcnt}, 0);

    // single requester, re-granted through the wrap-around search
    rem[2] = 8; dat[2] = 8'h10; apply();
    expect_burst(2, 8'h10, 4, 2);
    expect_burst(2, 8'h14, 4, 7);
    run(14, "single");
    check("single_wcnt", {28'd0, word_cnt}, 8);

    // round robin from reset
    do_reset();
    rem[0] = 8; dat[0] = 8'h40;
    rem[1] = 4; dat[1] = 8'h50;
    rem[2] = 4; dat[2] = 8'h60;
    rem[3] = 4; dat[3] = 8'h70;
    apply();
    expect_burst(0, 8'h40, 4, 2);
    expect_burst(1, 8'h50, 4, 7);
    expect_burst(2, 8'h60, 4, 12);
    expect_burst(3, 8'h70, 4, 17);
    expect_burst(0, 8'h44, 4, 22);
    run(30, "rr");
    check("rr_wcnt", {28'd0, word_cnt}, 20 % 16);

    // backpressure after the 2nd word for 5 cycles
    do_reset();
    rem[1] = 4; dat[1] = 8'h30; apply();
    expect_burst(1, 8'h30, 2, 2);
    expect_burst(1, 8'h32, 2, 9);
    for (int n = 1; n <= 14; n++) begin
      w_full = (n >= 4 && n <= 8);
      cycle();
      if (n >= 4 && n <= 8) begin
        check("stall_push", {31'd0, s_push}, 0);
        check("stall_ack", {28'd0, s_ack}, 0);
        check("stall_busy", {31'd0, s_busy}, 1);
      end
    end
    check("bp_sb_empty", sb.size(), 0);
    check("bp_wcnt", {28'd0, word_cnt}, 4);

    // early withdrawal by requester 3
    do_reset();
    rem[3] = 2; dat[3] = 8'h70; apply();
    expect_burst(3, 8'h70, 2, 2);
    expect_burst(1, 8'h50, 4, 6);
    expect_burst(2, 8'h60, 4, 11);
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin
        rem[1] = 4; dat[1] = 8'h50;
        rem[2] = 4; dat[2] = 8'h60;
        apply();
      end
      cycle();
      if (n == 5) begin
        check("wd_idle_busy", {31'd0, s_busy}, 0);
        check("wd_wcnt", {28'd0, s_wcnt}, 2);
      end
    end
    check("wd_sb_empty", sb.size(), 0);

    // reset pulse after the 1st word of a grant to requester 1
    do_reset();
    rem[1] = 4; dat[1] = 8'h50; apply();
    expect_burst(1, 8'h50, 1, 2);
    expect_burst(0, 8'h40, 4, 5);
    expect_burst(1, 8'h51, 3, 10);
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin
        rst = 1'b1;
        rem[0] = 4; dat[0] = 8'h40;
        apply();
      end
      if (n == 4) rst = 1'b0;
      cycle();
      if (n == 3) begin
        check("rstc_push", {31'd0, s_push}, 0);
        check("rstc_ack", {28'd0, s_ack}, 0);
        check("rstc_wdata", {24'd0, s_wdata}, 0);
      end
      if (n == 4) begin
        check("after_rst_busy", {31'd0, s_busy}, 0);
        check("after_rst_wcnt", {28'd0, s_wcnt}, 0);
        check("after_rst_gid", {30'd0, s_gid}, 0);
        check("after_rst_push", {31'd0, s_push}, 0);
      end
    end
    check("rstm_sb_empty", sb.size(), 0);

    // 4-bit counter wraps after 17 words
    do_reset();
    rem[0] = 17; dat[0] = 8'h00; apply();
    for (int k = 0; k < 4; k++) expect_burst(0, 4 * k, 4, 2 + 5 * k);
    expect_burst(0, 16, 1, 22);
    run(26, "wrap");
    check("wrap_wcnt", {28'd0, word_cnt}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
